rect_frame_reader: RTL and testbench
====================================

Name: rect_frame_reader

Overview:
- Streams the rectified 640x480 frame out of the destination frame buffer after the perspective pixel-transform writer has filled it.
- Issues raster-order reads on the buffer's read port using the same address map, {y[8:0], x[9:0]}.
- Absorbs the fixed BRAM read latency with a credit-limited FIFO.
- Presents pixels on a valid/ready stream, flagged for start-of-frame and end-of-line, to the display/output stage.

Parameters:
- RD_LATENCY, 2, cycles from mem_rd_en/mem_rd_addr to valid mem_rd_data (matches the frame buffer's 2-cycle fetch).
- FIFO_DEPTH, 4, output buffer entries; power of two, must be >= RD_LATENCY+1.
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame read; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until the last pixel is accepted.
- frame_done  out  1  one-cycle pulse in the cycle after the last pixel handshake.
- mem_rd_en  out  1  read strobe to the destination frame buffer.
- mem_rd_addr  out  19  read address {y, x}.
- mem_rd_data  in  36  read data, valid RD_LATENCY cycles after mem_rd_en.
- pix_data  out  36  pixel word.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts; a handshake occurs when pix_valid & pix_ready.
- pix_sof  out  1  qualifies pix_data at x=0, y=0.
- pix_eol  out  1  qualifies pix_data at x=H_ACTIVE-1.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: busy=0, frame_done=0, mem_rd_en=0, mem_rd_addr=0, pix_valid=0, pix_sof=0, pix_eol=0, pix_data=0.
- Reset also empties the FIFO, clears the read-valid shift register (RD_LATENCY bits), zeroes the credits and x/y counters, and returns the FSM to IDLE.
- Reset mid-frame: in-flight read returns are discarded; no pixel is emitted after reset.
- FSM IDLE:
  - On start, latch x=0, y=0 and go to ISSUE; busy=1 from the next cycle.
  - start while busy has no effect.
- FSM ISSUE:
  - Assert mem_rd_en with mem_rd_addr={y,x} in any cycle where credits < FIFO_DEPTH.
  - credits = FIFO occupancy + reads in flight.
  - credits increment on an issue and decrement on a pix handshake; both in one cycle leaves credits unchanged.
  - Advance x; at x=H_ACTIVE-1, wrap x to 0 and increment y.
  - After issuing {V_ACTIVE-1, H_ACTIVE-1} (addr 0x77E7F), go to DRAIN.
- FSM DRAIN:
  - No further reads.
  - When the handshake with pix_eol=1 at y=V_ACTIVE-1 occurs, pulse frame_done next cycle, drop busy that same cycle, and go to IDLE.
- Data path:
  - The read-valid shift register carries {valid, sof, eol} tags alongside each read.
  - mem_rd_data is written to the FIFO at the end of the cycle the tag emerges.
  - pix_valid comes from FIFO-not-empty (registered).
  - Latency: start sampled at edge S -> first mem_rd_en in cycle S+1 -> first pix_valid in cycle S+1+RD_LATENCY+1.
- Backpressure:
  - While pix_ready=0, pix_data/sof/eol hold stable and pix_valid stays high.
  - Issue stalls exactly when credits reach FIFO_DEPTH, so the FIFO never overflows.
  - FIFO push and pop in the same cycle is legal, including when the FIFO is full.
  - Throughput: 1 pixel/cycle with pix_ready held high.
- Counts: exactly H_ACTIVE*V_ACTIVE = 307200 handshakes per frame; pix_sof on exactly one beat; pix_eol on 480 beats.

Optional Feature:
- Macro: RECT_READER_CHECKSUM_EN.
- When defined:
  - Adds output frame_checksum [35:0], reset to 0 and cleared when start is accepted.
  - On each handshake, frame_checksum <= frame_checksum + pix_data, modulo 2^36.
  - frame_checksum is stable and valid in the frame_done cycle.
- When undefined: the port and the adder are absent; all other behaviour is identical.

Decomposition:
- Shared package rect_pkg holds:
  - constants H_ACTIVE=640, V_ACTIVE=480, ADDR_W=19, X_W=10, Y_W=9, PIX_W=36;
  - the FSM state enum {IDLE, ISSUE, DRAIN};
  - a function that packs {y, x} into an address.
- One sub-module: rect_sync_fifo, a parameterized depth/width synchronous FIFO with full/empty/count and same-cycle push/pop.

Test Plan:
- Reset, then start with pix_ready=1 and the memory model returning data=addr:
  - first mem_rd_en at S+1 with addr 0; first pix_valid at S+4 with data 0 and sof=1;
  - 307200 beats total, eol at data 0x0027F (y=0, x=639), last data 0x77E7F with eol=1;
  - frame_done one cycle after the last beat.
- Hold pix_ready=0 from the first pix_valid onward:
  - exactly FIFO_DEPTH=4 reads issued, then mem_rd_en stays 0;
  - pix_data holds 0;
  - releasing pix_ready resumes reads with no loss or duplication (full data sequence checked).
- Random pix_ready (50%) across a full frame: output sequence equals the raster address order; FIFO never overflows (assertion); credits never exceed 4.
- Pulse start again mid-frame at pixel 1000: ignored; busy stays 1; frame completes normally with 307200 beats.
- Assert reset during ISSUE at pixel 5000 with 3 reads in flight: next cycle pix_valid=0, busy=0, mem_rd_en=0; late mem_rd_data produces no beat; a new start yields sof on addr 0.
- With RECT_READER_CHECKSUM_EN and data=addr: frame_checksum equals the sum of all 307200 addresses mod 2^36, checked at frame_done.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared constants, FSM state type and address packing for the rectified-frame reader.
package rect_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int PIX_W    = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Frame buffer address map: line index in the upper bits, pixel index in the lower bits.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/rect_sync_fifo.sv
// Synchronous FIFO (power-of-two depth) with full/empty/count; push and pop may
// happen in the same cycle, including when full. Storage resets to zero.
module rect_sync_fifo import rect_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = PIX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rect_frame_reader.sv
// Raster-order reader of the rectified frame buffer onto a valid/ready pixel stream.
// Optional running frame checksum output enabled by RECT_READER_CHECKSUM_EN.
module rect_frame_reader import rect_pkg::*; #(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = rect_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = rect_pkg::V_ACTIVE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
`ifdef RECT_READER_CHECKSUM_EN
  , output logic [PIX_W-1:0] frame_checksum
`endif
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW  = PIX_W + 2;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);

  state_e                state_r;
  state_e                state_s;
  logic [X_W-1:0]        x_r;
  logic [Y_W-1:0]        y_r;
  logic [CW-1:0]         credits_r;
  logic [RD_LATENCY-1:0] vld_sr_r;
  logic [RD_LATENCY-1:0] sof_sr_r;
  logic [RD_LATENCY-1:0] eol_sr_r;
  logic                  frame_done_r;
  logic                  issue_s;
  logic                  pop_s;
  logic                  last_beat_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FW-1:0]         fifo_head_s;
  logic [FCW-1:0]        fifo_count_s;

  assign issue_s = (state_r == ISSUE) && (credits_r < DEPTH_C) && !fifo_full_s;
  assign pop_s   = pix_valid & pix_ready;
  // The final pixel is the only entry left once nothing is in flight.
  assign last_beat_s = (state_r == DRAIN) && pop_s && fifo_head_s[0] &&
                       (fifo_count_s == FCW'(1)) && (vld_sr_r == {RD_LATENCY{1'b0}});

  assign busy        = (state_r != IDLE);
  assign frame_done  = frame_done_r;
  assign mem_rd_en   = issue_s;
  assign mem_rd_addr = pack_addr(y_r, x_r);
  assign pix_valid   = ~fifo_empty_s;
  assign pix_data    = fifo_head_s[FW-1:2];
  assign pix_sof     = pix_valid & fifo_head_s[1];
  assign pix_eol     = pix_valid & fifo_head_s[0];

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ISSUE;
        else       state_s = IDLE;
      end
      ISSUE: begin
        if (issue_s && (x_r == X_LAST) && (y_r == Y_LAST)) state_s = DRAIN;
        else                                               state_s = ISSUE;
      end
      DRAIN: begin
        if (last_beat_s) state_s = IDLE;
        else             state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_done_r <= last_beat_s;
    end
  end

  // Raster counters hold the next address to read.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (issue_s) begin
      if (x_r == X_LAST) begin
        x_r <= {X_W{1'b0}};
        y_r <= (y_r == Y_LAST) ? {Y_W{1'b0}} : y_r + Y_W'(1);
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  // Credits: FIFO occupancy plus reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_r <= {CW{1'b0}};
    end else begin
      case ({issue_s, pop_s})
        2'b10:   credits_r <= credits_r + CW'(1);
        2'b01:   credits_r <= credits_r - CW'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Read tags travel with each read so they line up with the returning data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr_r <= {RD_LATENCY{1'b0}};
      sof_sr_r <= {RD_LATENCY{1'b0}};
      eol_sr_r <= {RD_LATENCY{1'b0}};
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_sr_r[i] <= vld_sr_r[i-1];
        sof_sr_r[i] <= sof_sr_r[i-1];
        eol_sr_r[i] <= eol_sr_r[i-1];
      end
      vld_sr_r[0] <= issue_s;
      sof_sr_r[0] <= issue_s && (x_r == {X_W{1'b0}}) && (y_r == {Y_W{1'b0}});
      eol_sr_r[0] <= issue_s && (x_r == X_LAST);
    end
  end

  rect_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_sr_r[RD_LATENCY-1]),
    .push_data ({mem_rd_data, sof_sr_r[RD_LATENCY-1], eol_sr_r[RD_LATENCY-1]}),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

`ifdef RECT_READER_CHECKSUM_EN
  logic [PIX_W-1:0] checksum_r;

  // Running modulo-2^36 sum of accepted pixels, cleared on each new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_r <= {PIX_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      checksum_r <= {PIX_W{1'b0}};
    end else if (pop_s) begin
      checksum_r <= checksum_r + pix_data;
    end
  end

  assign frame_checksum = checksum_r;
`endif

endmodule

// File: tb/tb_rect_frame_reader.sv
// Directed bench for rect_frame_reader on a reduced 16x4 frame; memory returns data = address.
module tb_rect_frame_reader;

  localparam int H    = 16;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        mem_rd_en;
  logic [18:0] mem_rd_addr;
  logic [35:0] mem_rd_data;
  logic [35:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
`ifdef RECT_READER_CHECKSUM_EN
  logic [35:0] frame_checksum;
`endif

  int errors = 0;
  int checks = 0;
  int beats = 0;
  int iss_cnt = 0;
  int max_out = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  logic        mon_clr = 1'b0;
  logic [18:0] mem_d1 = 19'd0;

  always #5 clk = ~clk;

  rect_frame_reader #(
    .RD_LATENCY (2),
    .FIFO_DEPTH (4),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .frame_done  (frame_done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol)
`ifdef RECT_READER_CHECKSUM_EN
    , .frame_checksum (frame_checksum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beat {data, sof, eol} for raster index n.
  function automatic logic [37:0] exp_beat(input int n);
    logic [18:0] a;
    a = 19'(((n / H) << 10) | (n % H));
    return {17'd0, a, (n == 0), ((n % H) == (H - 1))};
  endfunction

  // Two-cycle memory: data = address, valid two cycles after the read.
  always @(posedge clk) begin
    mem_d1      <= mem_rd_addr;
    mem_rd_data <= {17'd0, mem_d1};
  end

  always @(posedge clk) cyc++;

  // Stream monitor: every handshake is compared with the raster model.
  always @(negedge clk) begin
    if (mon_clr) begin
      beats   = 0;
      iss_cnt = 0;
      max_out = 0;
    end else begin
      if (iss_cnt - beats > max_out) max_out = iss_cnt - beats;
      if (mem_rd_en) iss_cnt++;
      if (pix_valid && pix_ready) begin
        chk("beat", 64'({pix_data, pix_sof, pix_eol}), 64'(exp_beat(beats)));
        beats++;
        last_beat_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < max_cyc) begin
      @(posedge clk); #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(frame_done), 64'd1);
    chk("done_lag", 64'(cyc - last_beat_cyc), 64'd1);
    chk("beats", 64'(beats), 64'(NPIX));
    chk("busy_at_done", 64'(busy), 64'd0);
`ifdef RECT_READER_CHECKSUM_EN
    // 16*1024*(0+1+2+3) + 4*(0+..+15) = 98304 + 480
    chk("checksum", 64'(frame_checksum), 64'd98784);
`endif
    @(negedge clk);
    chk("done_pulse", 64'(frame_done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_sof", 64'(pix_sof), 64'd0);
    chk("rst_eol", 64'(pix_eol), 64'd0);
    chk("rst_data", 64'(pix_data), 64'd0);

    // Streaming frame with latency checks.
    clear_mon();
    pix_ready = 1'b1;
    do_start();
    @(negedge clk);
    chk("lat_rd_en", 64'(mem_rd_en), 64'd1);
    chk("lat_addr0", 64'(mem_rd_addr), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_addr1", 64'(mem_rd_addr), 64'd1);
    chk("lat_valid_s2", 64'(pix_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid_s3", 64'(pix_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid_s4", 64'(pix_valid), 64'd1);
    chk("lat_sof", 64'(pix_sof), 64'd1);
    chk("lat_data", 64'(pix_data), 64'd0);
    wait_done(300, 1'b0);
    chk("max_credit_stream", 64'(max_out), 64'd3);

    // Backpressure: only FIFO_DEPTH reads before the stall.
    clear_mon();
    pix_ready = 1'b0;
    do_start();
    n = 0;
    while (pix_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 64'(pix_valid), 64'd1);
    repeat (8) @(negedge clk);
    chk("bp_issues", 64'(iss_cnt), 64'd4);
    chk("bp_rd_en", 64'(mem_rd_en), 64'd0);
    chk("bp_hold_valid", 64'(pix_valid), 64'd1);
    chk("bp_hold_data", 64'(pix_data), 64'd0);
    chk("bp_hold_sof", 64'(pix_sof), 64'd1);
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_done(300, 1'b0);

    // Random backpressure across a whole frame.
    clear_mon();
    do_start();
    wait_done(2000, 1'b1);
    chk("max_credit_rand", 64'(max_out <= 4), 64'd1);
    #1 pix_ready = 1'b1;

    // A second start mid-frame is ignored.
    clear_mon();
    do_start();
    n = 0;
    while (beats < 20 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("mid_start_busy", 64'(busy), 64'd1);
    wait_done(300, 1'b0);

    // Reset while reads are in flight.
    clear_mon();
    do_start();
    n = 0;
    while (beats < 40 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(pix_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rd_en", 64'(mem_rd_en), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pix_valid) seen = 1'b1;
    end
    chk("mrst_no_late_beat", 64'(seen), 64'd0);
    clear_mon();
    do_start();
    wait_done(300, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
